seven_segment_capture: RTL and testbench

- Receive-side counterpart to the team's hex-to-7-segment drivers.
- Monitors a time-multiplexed, active-low segment/digit-select bus (as driven to a scanned display) and recovers the 4-bit hex value shown on each digit.
- Qualifies each pattern for stability, flags illegal patterns, and expires stale digits.
- Used as a board self-check and loopback monitor behind the display drivers.

---
 rtl/seven_segment_capture.sv | 258 +++++++++++++++++++++++++
 tb/tb_seven_segment_capture.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_capture.sv
// seven_segment_capture
//   Watches a scanned, active-low 7-segment bus (segments + digit selects)
//   and recovers the hex nibble shown on each digit. A pattern is captured
//   only after STABLE_CYCLES identical synchronized samples with exactly one
//   digit selected. Illegal and blank glyphs are flagged, and each digit
//   loses its valid/blank status if it is not refreshed for TIMEOUT_CYCLES.
//
// Ports
//   CLOCK_50     in   system clock, rising edge
//   RESET_N      in   async active-low reset
//   SEG_N[6:0]   in   segments a..g, active-low, asynchronous
//   DIG_N[N-1:0] in   digit selects, active-low, asynchronous
//   VALUE        out  recovered nibble per digit, digit i at [4i+3:4i]
//   DIGIT_VALID  out  digit holds a fresh legal value
//   DIGIT_BLANK  out  last qualified pattern for the digit was all-off
//   PATTERN_ERR  out  last qualified pattern for the digit was not a glyph
//   UPDATE       out  one-cycle pulse when a digit register is written
//   UPDATE_IDX   out  digit written on the UPDATE cycle

// Per-digit result registers and staleness counter.
module ssc_digit #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cap_i,        // write this digit on this edge
    input  logic [3:0] cap_val_i,
    input  logic       cap_legal_i,
    input  logic       cap_blank_i,
    output logic [3:0] value_o,
    output logic       valid_o,
    output logic       blank_o,
    output logic       err_o
);
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT_CYCLES);

    logic [15:0] age_q, age_d;
    logic [3:0]  value_q, value_d;
    logic        valid_q, valid_d, blank_q, blank_d, err_q, err_d;

    always_comb begin
        age_d   = cap_i ? 16'd0 : ((age_q == 16'hFFFF) ? age_q : age_q + 16'd1);
        value_d = value_q;
        valid_d = valid_q;
        blank_d = blank_q;
        err_d   = err_q;
        if (cap_i) begin
            // a capture always beats an expiry on the same edge
            valid_d = cap_legal_i;
            blank_d = cap_blank_i;
            err_d   = !cap_legal_i && !cap_blank_i;
            if (cap_legal_i) value_d = cap_val_i;
        end else if (age_d >= TIMEOUT_C) begin
            // stale: value and error flag are kept for post-mortem
            valid_d = 1'b0;
            blank_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            age_q   <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            blank_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            age_q   <= age_d;
            value_q <= value_d;
            valid_q <= valid_d;
            blank_q <= blank_d;
            err_q   <= err_d;
        end
    end

    assign value_o = value_q;
    assign valid_o = valid_q;
    assign blank_o = blank_q;
    assign err_o   = err_q;
endmodule

module seven_segment_capture #(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic [6:0]              SEG_N,
    input  logic [NUM_DIGITS-1:0]   DIG_N,
    output logic [4*NUM_DIGITS-1:0] VALUE,
    output logic [NUM_DIGITS-1:0]   DIGIT_VALID,
    output logic [NUM_DIGITS-1:0]   DIGIT_BLANK,
    output logic [NUM_DIGITS-1:0]   PATTERN_ERR,
    output logic                    UPDATE,
    output logic [2:0]              UPDATE_IDX
);
    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_QUALIFY, S_CAPTURE, S_HOLD} state_e;

    // 2-flop synchronizers, reset to the idle (all-off, none selected) bus
    logic [6:0]            seg_s1_q, seg_s2_q;
    logic [NUM_DIGITS-1:0] dig_s1_q, dig_s2_q;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            seg_s1_q <= '1;
            seg_s2_q <= '1;
            dig_s1_q <= '1;
            dig_s2_q <= '1;
        end else begin
            seg_s1_q <= SEG_N;
            seg_s2_q <= seg_s1_q;
            dig_s1_q <= DIG_N;
            dig_s2_q <= dig_s1_q;
        end
    end

    // exactly one select low: the active-high vector is a power of two
    logic [NUM_DIGITS-1:0] sel_hot;
    logic                  sel_legal;
    assign sel_hot   = ~dig_s2_q;
    assign sel_legal = (sel_hot != '0) &&
                       ((sel_hot & (sel_hot - {{(NUM_DIGITS-1){1'b0}}, 1'b1})) == '0);

    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [6:0]            lat_seg_q, lat_seg_d;
    logic [NUM_DIGITS-1:0] lat_dig_q, lat_dig_d;
    logic                  cap_en, changed;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_seg_d = lat_seg_q;
        lat_dig_d = lat_dig_q;
        cap_en    = 1'b0;
        changed   = (seg_s2_q != lat_seg_q) || (dig_s2_q != lat_dig_q);
        case (state_q)
            S_IDLE: begin
                if (sel_legal) begin
                    state_d   = S_QUALIFY;
                    cnt_d     = 8'd1;
                    lat_seg_d = seg_s2_q;
                    lat_dig_d = dig_s2_q;
                end
            end
            S_QUALIFY, S_HOLD: begin
                if (changed) begin
                    if (sel_legal) begin
                        state_d   = S_QUALIFY;
                        cnt_d     = 8'd1;
                        lat_seg_d = seg_s2_q;
                        lat_dig_d = dig_s2_q;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = 8'd0;
                    end
                end else if (state_q == S_QUALIFY) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == STABLE_C) state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // the bus is not examined this cycle; HOLD compares next cycle
                cap_en  = 1'b1;
                state_d = S_HOLD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            lat_seg_q <= '0;
            lat_dig_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lat_seg_q <= lat_seg_d;
            lat_dig_q <= lat_dig_d;
        end
    end

    // glyph decode of the latched (qualified) pattern
    logic [3:0] gly_val;
    logic       gly_legal, gly_blank;

    always_comb begin
        gly_val   = 4'h0;
        gly_legal = 1'b1;
        gly_blank = 1'b0;
        case (lat_seg_q)
            7'h40: gly_val = 4'h0;
            7'h79: gly_val = 4'h1;
            7'h24: gly_val = 4'h2;
            7'h30: gly_val = 4'h3;
            7'h19: gly_val = 4'h4;
            7'h12: gly_val = 4'h5;
            7'h02: gly_val = 4'h6;
            7'h78: gly_val = 4'h7;
            7'h00: gly_val = 4'h8;
            7'h10: gly_val = 4'h9;
            7'h08: gly_val = 4'hA;
            7'h03: gly_val = 4'hB;
            7'h46: gly_val = 4'hC;
            7'h21: gly_val = 4'hD;
            7'h06: gly_val = 4'hE;
            7'h0E: gly_val = 4'hF;
            7'h7F: begin
                gly_legal = 1'b0;
                gly_blank = 1'b1;
            end
            default: gly_legal = 1'b0;
        endcase
    end

    logic [2:0] lat_idx;
    always_comb begin
        lat_idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (!lat_dig_q[i]) lat_idx = 3'(i);
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        ssc_digit #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_dig (
            .clk_i       (CLOCK_50),
            .rst_ni      (RESET_N),
            .cap_i       (cap_en & ~lat_dig_q[g]),
            .cap_val_i   (gly_val),
            .cap_legal_i (gly_legal),
            .cap_blank_i (gly_blank),
            .value_o     (VALUE[4*g +: 4]),
            .valid_o     (DIGIT_VALID[g]),
            .blank_o     (DIGIT_BLANK[g]),
            .err_o       (PATTERN_ERR[g])
        );
    end

    logic       upd_q;
    logic [2:0] upd_idx_q;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            upd_q     <= 1'b0;
            upd_idx_q <= '0;
        end else begin
            upd_q <= cap_en;
            if (cap_en) upd_idx_q <= lat_idx;
        end
    end

    assign UPDATE     = upd_q;
    assign UPDATE_IDX = upd_idx_q;
endmodule

// File: tb/tb_seven_segment_capture.sv
// tb_seven_segment_capture
//   Directed stimulus against seven_segment_capture (4 digits, 8 stable
//   cycles, timeout 100). A run-length model of the bus predicts every
//   output each cycle; literal checks pin latencies and key values.
module tb_seven_segment_capture;
    localparam int ND = 4;
    localparam int ST = 8;
    localparam int TO = 100;

    logic            CLOCK_50 = 1'b0;
    logic            RESET_N  = 1'b0;
    logic [6:0]      SEG_N    = '1;
    logic [ND-1:0]   DIG_N    = '1;
    logic [4*ND-1:0] VALUE;
    logic [ND-1:0]   DIGIT_VALID, DIGIT_BLANK, PATTERN_ERR;
    logic            UPDATE;
    logic [2:0]      UPDATE_IDX;

    int checks = 0;
    int errors = 0;
    int dut_upd_cnt = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    seven_segment_capture #(
        .NUM_DIGITS(ND), .STABLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .SEG_N       (SEG_N),
        .DIG_N       (DIG_N),
        .VALUE       (VALUE),
        .DIGIT_VALID (DIGIT_VALID),
        .DIGIT_BLANK (DIGIT_BLANK),
        .PATTERN_ERR (PATTERN_ERR),
        .UPDATE      (UPDATE),
        .UPDATE_IDX  (UPDATE_IDX)
    );

    // ---------------- model ----------------
    // glyph value, 16 = blank, -1 = illegal
    function automatic int glyph(input logic [6:0] s);
        case (s)
            7'h40: return 0;  7'h79: return 1;  7'h24: return 2;  7'h30: return 3;
            7'h19: return 4;  7'h12: return 5;  7'h02: return 6;  7'h78: return 7;
            7'h00: return 8;  7'h10: return 9;  7'h08: return 10; 7'h03: return 11;
            7'h46: return 12; 7'h21: return 13; 7'h06: return 14; 7'h0E: return 15;
            7'h7F: return 16;
            default: return -1;
        endcase
    endfunction

    // selected digit, or -1 unless exactly one select is low
    function automatic int sel_of(input logic [ND-1:0] d);
        int n = 0;
        int k = -1;
        for (int i = 0; i < ND; i++)
            if (!d[i]) begin n++; k = i; end
        return (n == 1) ? k : -1;
    endfunction

    logic [6:0]    m_seg1 = '1, m_seg2 = '1, run_seg = '0, pend_seg = '0;
    logic [ND-1:0] m_dig1 = '1, m_dig2 = '1, run_dig = '0;
    int            run_len = 0, pend_idx = 0, e_idx = 0;
    bit            pend = 0, e_upd = 0;
    logic [3:0]    e_val [ND];
    bit            e_valid [ND], e_blank [ND], e_err [ND];
    int            age [ND];

    initial begin
        for (int i = 0; i < ND; i++) begin
            e_val[i] = '0; e_valid[i] = 0; e_blank[i] = 0; e_err[i] = 0; age[i] = 0;
        end
        forever begin
            @(posedge CLOCK_50 or negedge RESET_N);
            if (!RESET_N) begin
                m_seg1 = '1; m_seg2 = '1; m_dig1 = '1; m_dig2 = '1;
                run_len = 0; pend = 0; e_upd = 0; e_idx = 0;
                for (int i = 0; i < ND; i++) begin
                    e_val[i] = '0; e_valid[i] = 0; e_blank[i] = 0; e_err[i] = 0; age[i] = 0;
                end
            end else begin
                bit skip;
                e_upd = 0;
                for (int i = 0; i < ND; i++) begin
                    if (pend && pend_idx == i) age[i] = 0;
                    else if (age[i] < 65535) age[i]++;
                    if (age[i] >= TO) begin e_valid[i] = 0; e_blank[i] = 0; end
                end
                skip = pend;
                if (pend) begin
                    int g;
                    g = glyph(pend_seg);
                    e_valid[pend_idx] = (g >= 0 && g < 16);
                    e_blank[pend_idx] = (g == 16);
                    e_err[pend_idx]   = (g < 0);
                    if (g >= 0 && g < 16) e_val[pend_idx] = 4'(g);
                    e_upd = 1;
                    e_idx = pend_idx;
                    pend  = 0;
                end
                // the sample taken on the write cycle is not examined
                if (!skip) begin
                    int k;
                    k = sel_of(m_dig2);
                    if (k < 0) run_len = 0;
                    else if (run_len > 0 && m_seg2 == run_seg && m_dig2 == run_dig) run_len++;
                    else begin run_len = 1; run_seg = m_seg2; run_dig = m_dig2; end
                    if (k >= 0 && run_len == ST) begin
                        pend = 1; pend_idx = k; pend_seg = run_seg;
                    end
                end
                m_seg2 = m_seg1; m_dig2 = m_dig1;
                m_seg1 = SEG_N;  m_dig1 = DIG_N;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        logic [4*ND-1:0] ev;
        logic [ND-1:0]   evl, ebl, eer;
        @(negedge CLOCK_50);
        for (int i = 0; i < ND; i++) begin
            ev[4*i +: 4] = e_val[i];
            evl[i] = e_valid[i]; ebl[i] = e_blank[i]; eer[i] = e_err[i];
        end
        checks++;
        if ({VALUE, DIGIT_VALID, DIGIT_BLANK, PATTERN_ERR, UPDATE} !== {ev, evl, ebl, eer, e_upd}) begin
            errors++;
            $display("FAIL cycle t=%0t VALUE=%h/%h VALID=%b/%b BLANK=%b/%b ERR=%b/%b UPD=%b/%b (act/exp)",
                     $time, VALUE, ev, DIGIT_VALID, evl, DIGIT_BLANK, ebl, PATTERN_ERR, eer, UPDATE, e_upd);
        end
        if (e_upd) begin
            checks++;
            if (UPDATE_IDX !== 3'(e_idx)) begin
                errors++;
                $display("FAIL update_idx t=%0t act=%0d exp=%0d", $time, UPDATE_IDX, e_idx);
            end
        end
        if (UPDATE === 1'b1) dut_upd_cnt++;
    end

    // ---------------- helpers ----------------
    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic hold_bus(input logic [6:0] s, input logic [ND-1:0] d, input int n);
        SEG_N = s;
        DIG_N = d;
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wait_update(input int limit, output int n);
        n = 0;
        for (int c = 1; c <= limit; c++) begin
            @(posedge CLOCK_50); #1;
            if (UPDATE) begin n = c; break; end
        end
        if (n == 0) begin
            checks++; errors++;
            $display("FAIL update_wait no UPDATE within %0d cycles", limit);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int n, u0, upd_at;

        // reset with bus noise
        repeat (2) @(posedge CLOCK_50);
        #1;
        for (int c = 0; c < 6; c++) begin
            SEG_N = 7'($urandom);
            DIG_N = ND'($urandom);
            @(posedge CLOCK_50); #1;
        end
        lit("rst_value", VALUE, 0);
        lit("rst_valid", DIGIT_VALID, 0);
        lit("rst_blank", DIGIT_BLANK, 0);
        lit("rst_err", PATTERN_ERR, 0);
        lit("rst_update", UPDATE, 0);
        hold_bus(7'h7F, '1, 3);
        RESET_N = 1'b1;
        u0 = dut_upd_cnt;
        hold_bus(7'h7F, '1, 10);
        lit("idle_no_update", dut_upd_cnt - u0, 0);

        // single digit, latency
        u0 = dut_upd_cnt;
        SEG_N = 7'h30; DIG_N = 4'b1110;
        wait_update(30, n);
        lit("single_latency", n, 11);
        lit("single_idx", UPDATE_IDX, 0);
        lit("single_value", VALUE[3:0], 3);
        lit("single_valid", DIGIT_VALID, 4'b0001);
        repeat (9) @(posedge CLOCK_50);
        #1;
        lit("single_count", dut_upd_cnt - u0, 1);
        hold_bus(7'h7F, '1, 4);

        // scan, two passes
        u0 = dut_upd_cnt;
        for (int p = 0; p < 2; p++) begin
            hold_bus(7'h19, 4'b1110, 16);
            hold_bus(7'h03, 4'b1101, 16);
            hold_bus(7'h46, 4'b1011, 16);
            hold_bus(7'h0E, 4'b0111, 16);
        end
        lit("scan_value", VALUE, 16'hFCB4);
        lit("scan_valid", DIGIT_VALID, 4'hF);
        lit("scan_count", dut_upd_cnt - u0, 8);
        hold_bus(7'h7F, '1, 4);

        // short slot then glitched slot on digit 2
        u0 = dut_upd_cnt;
        hold_bus(7'h24, 4'b1011, 5);
        upd_at = 0;
        for (int c = 0; c < 20; c++) begin
            if (c < 12) begin
                SEG_N = (c == 3) ? 7'h02 : 7'h12;
                DIG_N = 4'b1011;
            end else begin
                SEG_N = 7'h7F;
                DIG_N = '1;
            end
            @(posedge CLOCK_50); #1;
            if (UPDATE && upd_at == 0) upd_at = c + 1;
        end
        lit("glitch_update_at", upd_at, 15);
        lit("glitch_count", dut_upd_cnt - u0, 1);
        lit("glitch_value", VALUE[11:8], 5);

        // illegal, blank, multi-select on digit 1
        hold_bus(7'h55, 4'b1101, 14);
        lit("illegal_err", PATTERN_ERR[1], 1);
        lit("illegal_valid", DIGIT_VALID[1], 0);
        lit("illegal_value", VALUE[7:4], 4'hB);
        hold_bus(7'h7F, 4'b1101, 14);
        lit("blank_err", PATTERN_ERR[1], 0);
        lit("blank_flag", DIGIT_BLANK[1], 1);
        u0 = dut_upd_cnt;
        hold_bus(7'h40, 4'b1100, 20);
        lit("multi_sel_count", dut_upd_cnt - u0, 0);
        hold_bus(7'h7F, '1, 4);

        // timeout on digit 0
        SEG_N = 7'h79; DIG_N = 4'b1110;
        wait_update(30, n);
        lit("to_cap_value", VALUE[3:0], 1);
        SEG_N = 7'h7F; DIG_N = '1;
        n = 0;
        for (int k = 1; k <= 150; k++) begin
            @(posedge CLOCK_50); #1;
            if (!DIGIT_VALID[0]) begin n = k; break; end
        end
        lit("to_age", n, 100);
        lit("to_value_kept", VALUE[3:0], 1);

        // recapture landing on the timeout edge
        SEG_N = 7'h79; DIG_N = 4'b1110;
        wait_update(30, n);
        SEG_N = 7'h7F; DIG_N = '1;
        repeat (89) @(posedge CLOCK_50);
        #1;
        SEG_N = 7'h24; DIG_N = 4'b1110;
        repeat (11) @(posedge CLOCK_50);
        #1;
        lit("to_recap_update", UPDATE, 1);
        lit("to_recap_valid", DIGIT_VALID[0], 1);
        lit("to_recap_value", VALUE[3:0], 2);
        hold_bus(7'h24, 4'b1110, 5);
        lit("to_recap_hold", DIGIT_VALID[0], 1);
        hold_bus(7'h7F, '1, 4);

        // reset during qualification
        u0 = dut_upd_cnt;
        hold_bus(7'h40, 4'b0111, 6);
        RESET_N = 1'b0;
        #1;
        lit("midrst_value", VALUE, 0);
        lit("midrst_valid", DIGIT_VALID, 0);
        lit("midrst_update", UPDATE, 0);
        hold_bus(7'h40, 4'b0111, 3);
        lit("midrst_count", dut_upd_cnt - u0, 0);
        SEG_N = 7'h7F; DIG_N = '1;
        RESET_N = 1'b1;
        hold_bus(7'h7F, '1, 10);
        lit("post_rst_count", dut_upd_cnt - u0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
